// File: rtl/riscv_dmem_ctrl_if.sv
// ============================================================================
// Module   : riscv_dmem_ctrl_if
// Purpose  : Request/response bundle between the MEM stage and the data memory
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface riscv_dmem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

`default_nettype wire

// File: rtl/riscv_dmem_ctrl.sv
// ============================================================================
// Module   : riscv_dmem_ctrl
// Purpose  : RV32 data memory: sized loads/stores, extension, error checks,
//            registered one-cycle read and an optional post-reset clear sweep
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_dmem_ctrl #(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_dmem_ctrl_if.slave     bus
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               live_q;

    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic               zero_q, zero_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        rd_word_q;

    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-3:0]  word_idx;
    logic [1:0]         offset;
    logic [IDX_W-1:0]   req_idx;
    logic               f3_legal;
    logic               misaligned;
    logic               in_range;
    logic               req_err;
    logic               req_ready;
    logic               accept;
    logic               do_store;
    logic               do_load;
    logic               clr_we;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata;
    logic [IDX_W-1:0]   mem_addr;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [31:0]        rdata_ext;

    // ------------------------------------------------------------------
    // Request decode and error classification
    // ------------------------------------------------------------------
    always_comb begin
        word_idx = bus.req_addr[ADDR_W-1:2];
        offset   = bus.req_addr[1:0];
        req_idx  = IDX_W'(word_idx);
        in_range = 32'(word_idx) < 32'(DEPTH);

        if (bus.req_we) begin
            f3_legal = (bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_H) ||
                       (bus.req_funct3 == F3_W);
        end else begin
            f3_legal = (bus.req_funct3 == F3_B)  || (bus.req_funct3 == F3_H)  ||
                       (bus.req_funct3 == F3_W)  || (bus.req_funct3 == F3_BU) ||
                       (bus.req_funct3 == F3_HU);
        end

        // funct3[1:0] is the access size for every legal encoding
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && offset[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (offset != 2'b00));

        req_err   = !f3_legal || misaligned || !in_range;
        req_ready = live_q && (state_q == ST_IDLE);
        accept    = bus.req_valid && req_ready;
        do_store  = accept &&  bus.req_we && !req_err;
        do_load   = accept && !bus.req_we && !req_err;
    end

    // ------------------------------------------------------------------
    // Sweep / idle state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_IDLE;
            end
            cnt_q  <= '0;
            live_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write port: sweep or sized store with replicated data
    // ------------------------------------------------------------------
    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        mem_addr  = req_idx;
        if (clr_we) begin
            mem_be   = 4'b1111;
            mem_addr = cnt_q;
        end else if (do_store) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << offset;
                    mem_wdata = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << offset;
                    mem_wdata = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = bus.req_wdata;
                end
            endcase
        end
    end

    // RAM array and its read register carry no reset so they map onto block RAM
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) begin
                mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (do_load) begin
            rd_word_q <= mem[req_idx];
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_comb begin
        resp_valid_d = accept;
        resp_err_d   = accept && req_err;
        zero_d       = zero_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        if (accept) begin
            zero_d   = !do_load;
            funct3_d = bus.req_funct3;
            off_d    = offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            zero_q       <= 1'b1;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            zero_q       <= zero_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
        end
    end

    // Lane select and extension work only from registered state
    always_comb begin
        lane_b = rd_word_q[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (funct3_q)
            F3_B:    rdata_ext = {{24{lane_b[7]}}, lane_b};
            F3_H:    rdata_ext = {{16{lane_h[15]}}, lane_h};
            F3_W:    rdata_ext = rd_word_q;
            F3_BU:   rdata_ext = {24'h0, lane_b};
            F3_HU:   rdata_ext = {16'h0, lane_h};
            default: rdata_ext = 32'h0;
        endcase
        if (zero_q) begin
            rdata_ext = 32'h0;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_ext;

endmodule

`default_nettype wire

// File: tb/tb_riscv_dmem_ctrl.sv
// ============================================================================
// Module   : tb_riscv_dmem_ctrl
// Purpose  : Directed self-checking bench for riscv_dmem_ctrl
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_riscv_dmem_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 10;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    riscv_dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    riscv_dmem_ctrl #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    // single request, response checked in the following cycle
    task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                        input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        drive(we, f3, a, wd);
        step();
        idle();
        check({tag, ".valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, ".rdata"}, bus.resp_rdata, exp_rd);
        check({tag, ".err"},   32'(bus.resp_err), 32'(exp_err));
    endtask

    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.req_ready && n < 400);
        check(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = 32'h0;
        idle();
        repeat (3) step();

        check("rst.ready", 32'(bus.req_ready),  32'd0);
        check("rst.valid", 32'(bus.resp_valid), 32'd0);
        check("rst.rdata", bus.resp_rdata,      32'h0);
        check("rst.err",   32'(bus.resp_err),   32'd0);

        rst_n = 1'b1;
        wait_sweep("sweep.len");
        xfer("lw_top", 1'b0, LW, 10'h3FC, 32'h0, 32'h0000_0000, 1'b0);

        xfer("sw10", 1'b1, LW, 10'h010, 32'h80FF_7F01, 32'h0, 1'b0);
        xfer("sb12", 1'b1, LB, 10'h012, 32'h1234_56AA, 32'h0, 1'b0);
        xfer("lw10_sb", 1'b0, LW, 10'h010, 32'h0, 32'h80AA_7F01, 1'b0);

        xfer("sw10b", 1'b1, LW, 10'h010, 32'h80FF_7F01, 32'h0, 1'b0);
        xfer("lb13",  1'b0, LB,  10'h013, 32'h0, 32'hFFFF_FF80, 1'b0);
        xfer("lbu13", 1'b0, LBU, 10'h013, 32'h0, 32'h0000_0080, 1'b0);
        xfer("lb10",  1'b0, LB,  10'h010, 32'h0, 32'h0000_0001, 1'b0);
        xfer("lh10",  1'b0, LH,  10'h010, 32'h0, 32'h0000_7F01, 1'b0);
        xfer("lh12",  1'b0, LH,  10'h012, 32'h0, 32'hFFFF_80FF, 1'b0);
        xfer("lhu12", 1'b0, LHU, 10'h012, 32'h0, 32'h0000_80FF, 1'b0);

        step();
        check("hold.valid", 32'(bus.resp_valid), 32'd0);
        check("hold.rdata", bus.resp_rdata, 32'h0000_80FF);

        xfer("sw14", 1'b1, LW, 10'h014, 32'h1122_3344, 32'h0, 1'b0);
        xfer("sh16", 1'b1, LH, 10'h016, 32'h5566_BEEF, 32'h0, 1'b0);
        xfer("lw14_sh", 1'b0, LW, 10'h014, 32'h0, 32'hBEEF_3344, 1'b0);
        xfer("lh11_mis", 1'b0, LH, 10'h011, 32'h0, 32'h0, 1'b1);
        xfer("sw16_mis", 1'b1, LW, 10'h016, 32'hDEAD_BEEF, 32'h0, 1'b1);
        xfer("lw14_keep", 1'b0, LW, 10'h014, 32'h0, 32'hBEEF_3344, 1'b0);

        xfer("ld_ill", 1'b0, 3'b011, 10'h010, 32'h0, 32'h0, 1'b1);
        xfer("st_ill", 1'b1, 3'b100, 10'h010, 32'h0, 32'h0, 1'b1);
        xfer("lw10_keep", 1'b0, LW, 10'h010, 32'h0, 32'h80FF_7F01, 1'b0);

        drive(1'b1, LW, 10'h020, 32'hCAFE_F00D);
        step();
        check("b2b0.valid", 32'(bus.resp_valid), 32'd1);
        check("b2b0.rdata", bus.resp_rdata, 32'h0);
        drive(1'b0, LW, 10'h020, 32'h0);
        step();
        check("b2b1.valid", 32'(bus.resp_valid), 32'd1);
        check("b2b1.rdata", bus.resp_rdata, 32'hCAFE_F00D);
        drive(1'b0, LW, 10'h020, 32'h0);
        step();
        idle();
        check("b2b2.valid", 32'(bus.resp_valid), 32'd1);
        check("b2b2.rdata", bus.resp_rdata, 32'hCAFE_F00D);
        step();
        check("b2b_end.valid", 32'(bus.resp_valid), 32'd0);

        // asynchronous reset while a response is being presented
        xfer("pre_rst", 1'b0, LW, 10'h010, 32'h0, 32'h80FF_7F01, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(bus.resp_valid), 32'd0);
        check("arst.rdata", bus.resp_rdata,      32'h0);
        check("arst.ready", 32'(bus.req_ready),  32'd0);
        step();
        rst_n = 1'b1;
        repeat (100) step();
        check("mid.ready", 32'(bus.req_ready), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst.ready", 32'(bus.req_ready),  32'd0);
        check("mid_rst.valid", 32'(bus.resp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        wait_sweep("resweep.len");
        xfer("lw10_clr", 1'b0, LW, 10'h010, 32'h0, 32'h0, 1'b0);
        xfer("lw20_clr", 1'b0, LW, 10'h020, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
